ping_gate: RTL and testbench

Transmit-and-time front end for the phase_ping path. On a trigger it drives a complementary carrier burst to the transducer, blanks ring-down, then listens on the 1-bit comparator input for the echo. It outputs a `gate` that is high from burst start to echo or timeout, plus a 16-bit time-of-flight. `gate` feeds the downstream high-time counter and UART reporter, which reports on the falling edge of `gate`.

---
 rtl/ping_pkg.sv | 24 ++
 rtl/carrier_gen.sv | 49 ++++
 rtl/ping_gate.sv | 190 +++++++++++++++++++
 tb/tb_ping_gate.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pkg.sv
// ping_pkg: shared types and defaults for the ping_gate transmit-and-time front end.
//   ping_state_t  - FSM state encoding (IDLE, BURST, BLANK, LISTEN, DONE)
//   TOF_W         - width of the time-of-flight / elapsed counter
//   DEF_*         - default parameter values for a 48 MHz clock and 40 kHz carrier
package ping_pkg;

  localparam int unsigned TOF_W = 16;

  localparam int unsigned DEF_CARRIER_DIV    = 600;
  localparam int unsigned DEF_BURST_CYCLES   = 8;
  localparam int unsigned DEF_BLANK_CYCLES   = 4800;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEF_MIN_HIGH       = 3;
  localparam int unsigned DEF_REPEAT_CYCLES  = 4800000;

  typedef enum logic [2:0] {
    StIdle,
    StBurst,
    StBlank,
    StListen,
    StDone
  } ping_state_t;

endpackage

// File: rtl/carrier_gen.sv
// carrier_gen: complementary carrier burst generator.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   en          - high for the whole burst; low clears the divider and forces outputs low
//   tx_p, tx_n  - complementary carrier; tx_p starts high in the first enabled cycle
//   burst_done  - high in the last cycle of the final half-period
module carrier_gen #(
  parameter int unsigned CARRIER_DIV  = 600,
  parameter int unsigned BURST_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tx_p,
  output logic tx_n,
  output logic burst_done
);

  localparam int unsigned DW     = $clog2(CARRIER_DIV + 1);
  localparam int unsigned HALVES = 2 * BURST_CYCLES;
  localparam int unsigned HW     = $clog2(HALVES + 1);

  logic [DW-1:0] div_q;
  logic [HW-1:0] half_q;
  logic          div_wrap;

  assign div_wrap = (div_q == DW'(CARRIER_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      half_q <= '0;
    end else if (!en) begin
      div_q  <= '0;
      half_q <= '0;
    end else if (div_wrap) begin
      div_q  <= '0;
      half_q <= half_q + HW'(1);
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Even half-periods drive tx_p, odd ones tx_n; both low whenever disabled.
  assign tx_p       = en & ~half_q[0];
  assign tx_n       = en & half_q[0];
  assign burst_done = en & div_wrap & (half_q == HW'(HALVES - 1));

endmodule

// File: rtl/ping_gate.sv
// ping_gate: ultrasonic ping transmit, ring-down blanking and echo timing.
// Ports:
//   clk, rst          - 48 MHz clock, asynchronous active-low reset
//   start             - single-cycle trigger, ignored while busy
//   sig               - comparator output, asynchronous to clk
//   tx_p, tx_n        - complementary carrier drive
//   gate              - high from burst start until echo or timeout
//   busy              - high in any state other than idle
//   tof               - gate high time of the last ping, in clocks
//   echo_ok, timeout  - one-cycle completion pulses
// Build option: define PING_AUTO_REPEAT_EN to add a free-running trigger every
// REPEAT_CYCLES clocks, ORed with start.
module ping_gate import ping_pkg::*; #(
  parameter int unsigned CARRIER_DIV    = DEF_CARRIER_DIV,
  parameter int unsigned BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MIN_HIGH       = DEF_MIN_HIGH,
  parameter int unsigned REPEAT_CYCLES  = DEF_REPEAT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig,
  output logic             tx_p,
  output logic             tx_n,
  output logic             gate,
  output logic             busy,
  output logic [TOF_W-1:0] tof,
  output logic             echo_ok,
  output logic             timeout
);

  localparam int unsigned QW = $clog2(MIN_HIGH + 1);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

  ping_state_t      state_q;
  logic [TOF_W-1:0] elapsed_q, elapsed_inc;
  logic [BW-1:0]    blank_q;
  logic [QW-1:0]    qual_q, qual_nxt;
  logic             sig_m, sig_s, sig_prev;
  logic             timeout_hit, echo_hit, burst_done, carrier_en, trig;

  // Two-flop synchronizer, plus one more stage to spot low->high transitions of sig_s.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_m    <= 1'b0;
      sig_s    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_m    <= sig;
      sig_s    <= sig_m;
      sig_prev <= sig_s;
    end
  end

`ifdef PING_AUTO_REPEAT_EN
  logic [31:0] rep_q;
  logic        rep_fire;

  assign rep_fire = (rep_q == 32'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_fire ? '0 : rep_q + 32'd1;
    end
  end

  // Only honoured in idle, so a repeat tick during a ping is simply dropped.
  assign trig = start | rep_fire;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign trig          = start;
`endif

  always_comb begin
    // Saturating increment: the elapsed count never wraps.
    elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + TOF_W'(1);
    timeout_hit = (elapsed_inc >= TOF_W'(TIMEOUT_CYCLES));

    // Qualifier only arms on a rising edge; a level that was already high stays ignored.
    qual_nxt = '0;
    if (sig_s) begin
      if (qual_q != '0) begin
        qual_nxt = qual_q + QW'(1);
      end else if (!sig_prev) begin
        qual_nxt = QW'(1);
      end
    end
    echo_hit = (qual_nxt == QW'(MIN_HIGH));
  end

  assign carrier_en = (state_q == StBurst);

  carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .BURST_CYCLES(BURST_CYCLES)
  ) u_carrier (
    .clk       (clk),
    .rst       (rst),
    .en        (carrier_en),
    .tx_p      (tx_p),
    .tx_n      (tx_n),
    .burst_done(burst_done)
  );

  // Completion is registered on the detecting edge, so tof is the final gate high time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      elapsed_q <= '0;
      blank_q   <= '0;
      qual_q    <= '0;
      gate      <= 1'b0;
      busy      <= 1'b0;
      tof       <= '0;
      echo_ok   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      echo_ok <= 1'b0;
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          elapsed_q <= '0;
          qual_q    <= '0;
          if (trig) begin
            state_q <= StBurst;
            gate    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StBurst: begin
          elapsed_q <= elapsed_inc;
          blank_q   <= '0;
          if (timeout_hit) begin
            state_q <= StDone;
            gate    <= 1'b0;
            tof     <= elapsed_inc;
            timeout <= 1'b1;
          end else if (burst_done) begin
            state_q <= StBlank;
          end
        end
        StBlank: begin
          elapsed_q <= elapsed_inc;
          qual_q    <= '0;
          if (timeout_hit) begin
            state_q <= StDone;
            gate    <= 1'b0;
            tof     <= elapsed_inc;
            timeout <= 1'b1;
          end else if (blank_q == BW'(BLANK_CYCLES - 1)) begin
            state_q <= StListen;
          end else begin
            blank_q <= blank_q + BW'(1);
          end
        end
        StListen: begin
          elapsed_q <= elapsed_inc;
          qual_q    <= qual_nxt;
          // Echo takes priority over a simultaneous timeout.
          if (echo_hit) begin
            state_q <= StDone;
            gate    <= 1'b0;
            tof     <= elapsed_inc;
            echo_ok <= 1'b1;
          end else if (timeout_hit) begin
            state_q <= StDone;
            gate    <= 1'b0;
            tof     <= elapsed_inc;
            timeout <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          gate    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ping_gate.sv
// tb_ping_gate: directed scoreboard bench for ping_gate with small bench parameters.
// Expected completions (kind + tof) are queued when a ping is issued; a monitor pops
// and compares whenever echo_ok or timeout pulses.
module tb_ping_gate;

  logic        clk, rst, start, sig;
  logic        tx_p, tx_n, gate, busy, echo_ok, timeout;
  logic [15:0] tof;

  typedef struct {
    logic        is_echo;
    logic [15:0] tof;
  } exp_t;

  exp_t sb_q[$];
  int   rise_cyc[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   hi_cnt   = 0;
  int   hi_len   = 0;
  logic gate_prev = 1'b0;

  ping_gate #(
    .CARRIER_DIV   (2),
    .BURST_CYCLES  (2),
    .BLANK_CYCLES  (10),
    .TIMEOUT_CYCLES(100),
    .MIN_HIGH      (3),
    .REPEAT_CYCLES (200)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sig    (sig),
    .tx_p   (tx_p),
    .tx_n   (tx_n),
    .gate   (gate),
    .busy   (busy),
    .tof    (tof),
    .echo_ok(echo_ok),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Gate high-time measurement and rise timestamps.
  initial forever begin
    @(negedge clk);
    if (gate && !gate_prev) begin
      hi_cnt = 1;
      rise_cyc.push_back(cyc);
    end else if (gate) begin
      hi_cnt++;
    end
    if (!gate && gate_prev) hi_len = hi_cnt;
    gate_prev = gate;
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (echo_ok || timeout)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'({echo_ok, timeout}), 0);
        end else begin
          e = sb_q.pop_front();
          check("done_kind", 32'({echo_ok, timeout}), e.is_echo ? 32'd2 : 32'd1);
          check("tof", 32'(tof), 32'(e.tof));
          check("gate_low_at_done", 32'(gate), 0);
        end
      end
    end
  end

  task automatic expect_done(input logic is_echo, input int t);
    exp_t e;
    e.is_echo = is_echo;
    e.tof     = 16'(t);
    sb_q.push_back(e);
  endtask

  // Returns just after the edge where gate rises.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    check({name, "_idle"}, 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_p"}, 32'(tx_p), 0);
    check({name, "_tx_n"}, 32'(tx_n), 0);
    check({name, "_gate"}, 32'(gate), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_tof"}, 32'(tof), 0);
    check({name, "_echo_ok"}, 32'(echo_ok), 0);
    check({name, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ep, en;
    rst   = 1'b1;
    start = 1'b0;
    sig   = 1'b0;
    #3 rst = 1'b0;
    #10;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifdef PING_AUTO_REPEAT_EN
    begin
      int n = 0;
      for (int i = 0; i < 3; i++) expect_done(1'b0, 100);
      while (rise_cyc.size() < 3 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("repeat_rises", rise_cyc.size(), 3);
      if (rise_cyc.size() >= 3) begin
        check("repeat_period_1", rise_cyc[1] - rise_cyc[0], 200);
        check("repeat_period_2", rise_cyc[2] - rise_cyc[1], 200);
      end
      wait_idle("repeat");
    end
`else
    // Burst shape, then timeout with sig held low.
    expect_done(1'b0, 100);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ep = (i < 8) ? ((i % 4) < 2) : 1'b0;
      en = (i < 8) ? !ep : 1'b0;
      check($sformatf("burst_tx_p_%0d", i), 32'(tx_p), 32'(ep));
      check($sformatf("burst_tx_n_%0d", i), 32'(tx_n), 32'(en));
    end
    wait_idle("timeout");
    check("timeout_gate_len", hi_len, 100);

    // Echo: sig rises 40 clocks after gate rise -> 2 sync + 3 qualify -> tof 45.
    expect_done(1'b1, 45);
    pulse_start();
    repeat (40) @(posedge clk);
    #1 sig = 1'b1;
    wait_idle("echo");
    check("echo_gate_len", hi_len, 45);
    check("echo_pulse_single", 32'(echo_ok), 0);
    sig = 1'b0;

    // sig high from the start of blanking: no fresh rising edge in listen.
    expect_done(1'b0, 100);
    pulse_start();
    repeat (8) @(posedge clk);
    #1 sig = 1'b1;
    wait_idle("stuck");
    check("stuck_gate_len", hi_len, 100);
    sig = 1'b0;

    // Two-clock glitch in listen is too short to qualify.
    expect_done(1'b0, 100);
    pulse_start();
    repeat (30) @(posedge clk);
    #1 sig = 1'b1;
    repeat (2) @(posedge clk);
    #1 sig = 1'b0;
    wait_idle("glitch");
    check("glitch_gate_len", hi_len, 100);

    // Second start mid-burst is ignored.
    expect_done(1'b0, 100);
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("busy");
    check("busy_gate_len", hi_len, 100);
    repeat (5) @(negedge clk);
    check("busy_no_second_ping", 32'({gate, busy}), 0);

    // Reset in listen clears everything at once, including tof.
    pulse_start();
    repeat (25) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Normal operation after reset: sig rises 20 clocks after gate -> tof 25.
    expect_done(1'b1, 25);
    pulse_start();
    repeat (20) @(posedge clk);
    #1 sig = 1'b1;
    wait_idle("post_rst");
    check("post_rst_gate_len", hi_len, 25);
    sig = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
